tile_map_scheduler: RTL and testbench
=====================================

// Module: tile_map_scheduler
// PURPOSE
//  Upstream sequencer for the 8x8 tile drawer. Once per frame it walks the visible
//  tile grid and reads each tile index from the map RAM, applying a coarse
//  horizontal scroll. It then hands the tile origin and ID to the drawer using a
//  one-cycle draw pulse and waits for drawDone before it moves to the next tile.
//  It sits between the frame timing logic (frame_start) and the tile drawer/pixel path.
// PARAMETERS
//  SCR_TX   20  visible tiles per row (160 px / 8)
//  SCR_TY   15  visible tile rows (120 px / 8)
//  MAP_TX   64  map width in tiles; power of 2, column index wraps modulo MAP_TX
//  MAP_AW   10  map RAM address width (>= clog2(SCR_TY*MAP_TX))
//  ID_W     4   tile-index width
//  SKIP_EMPTY 1 when 1, tile_id==0 is not drawn (no draw pulse)
// PORTS
//  clock       in  1       system clock
//  resetn      in  1       asynchronous, active-low reset
//  frame_start in  1       one-cycle request to render a frame; ignored unless IDLE
//  scroll_col  in  6       first visible map column (clog2(MAP_TX)); sampled on accepted frame_start
//  map_addr    out MAP_AW  map RAM read address (synchronous RAM, 1-cycle read latency)
//  map_q       in  ID_W    map RAM read data
//  draw        out 1       one-cycle pulse to tile drawer
//  drawDone    in  1       tile drawer idle/finished (high while drawer waiting)
//  tile_x      out 8       pixel x origin of current tile = col*8 (0..152)
//  tile_y      out 7       pixel y origin of current tile = row*8 (0..112)
//  tile_id     out ID_W    bitmap index of current tile
//  busy        out 1       high from accepted frame_start until frameDone
//  frameDone   out 1       one-cycle pulse after last tile finishes
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; draw, busy, frameDone=0; tile_x, tile_y,
//   tile_id, map_addr=0; col/row counters=0.
//  FSM states and transitions:
//   IDLE   : frame_start=1 -> latch scroll_col, row=col=0, busy=1, go to FETCH.
//   FETCH  : map_addr = row*MAP_TX + ((col+scroll_lat) mod MAP_TX); go to MEMWAIT.
//   MEMWAIT: 1-cycle RAM latency; go to LATCH.
//   LATCH  : register tile_id=map_q, tile_x=col*8, tile_y=row*8.
//            If SKIP_EMPTY && map_q==0, go to NEXT; otherwise go to ISSUE.
//   ISSUE  : draw=1 for exactly this cycle; go to BUSY. drawDone is not looked at here.
//   BUSY   : wait for drawDone=1 (the drawer drops it from the cycle after draw); then go to NEXT.
//   NEXT   : col==SCR_TX-1 -> col=0, row++; else col++.
//            When col==SCR_TX-1 && row==SCR_TY-1, go to DONE; otherwise go to FETCH.
//   DONE   : frameDone=1 for one cycle, busy=0; go to IDLE.
//  tile_x, tile_y and tile_id are stable from LATCH until the next LATCH, so they are held
//   for the whole drawer operation.
//  Arithmetic: the column sum is computed in clog2(MAP_TX) bits and wraps naturally
//   (scroll_col=60, col=5 -> map column 1). The row multiply is a shift; MAP_TX is a power of 2.
//  frame_start outside IDLE is dropped, not queued. A scroll_col change mid-frame has no
//   effect until the next frame.
//  drawDone stuck low leaves the block in BUSY indefinitely; no timeout.
//  Per-tile cost: 5 cycles + drawer time for a drawn tile; 4 cycles for a skipped tile.
// STRUCTURE
//  Shared package/include: SCR_TX, SCR_TY, TILE_PX=8, MAP_TX, and the state encoding
//   localparams (IDLE..DONE, 3 bits). The tile drawer and pixel path reuse the same
//   screen constants.
//  Sub-module tile_grid_counter: col/row counters with inc, clr and a last flag
//   (col==SCR_TX-1 && row==SCR_TY-1). The FSM and address/origin logic stay at top level.
// TESTING
//  1 Reset mid-BUSY: assert resetn=0 -> all outputs 0 at once (async), state IDLE;
//    frame_start after release starts a fresh frame at row0/col0.
//  2 Full frame, drawer model with drawDone low 10 cycles after draw, map_q=1 everywhere:
//    exactly 300 draw pulses; the last has tile_x=152, tile_y=112; one frameDone; busy low after it.
//  3 Scroll wrap: scroll_col=60, map[r][c]=c+1 -> row0 map_addr sequence
//    60,61,62,63,0,1..15; tile_x stays 0,8,..152.
//  4 Skip empty: map all 0 except map[2][3]=7 -> exactly one draw with tile_x=24,
//    tile_y=16, tile_id=7; frame takes 300*4 + 1 + drawer cycles + 1.
//  5 frame_start pulsed while busy -> ignored: no second frame, frameDone count stays 1.
//  6 Handshake: drawer holds drawDone low 50 cycles -> no FETCH/map_addr change and
//    tile_x/y/id held until drawDone=1.

Source files
------------

// File: rtl/tile_map_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tile_map_scheduler_pkg
//   Screen geometry and FSM state encoding shared by the tile map scheduler,
//   its grid counter, the tile drawer and the pixel path.
//
//   SCR_TX / SCR_TY : visible tiles per row / visible tile rows
//   TILE_PX         : tile edge in pixels (power of 2)
//   MAP_TX          : map width in tiles (power of 2, columns wrap modulo it)
//   ST_*            : 3-bit scheduler state codes
// ---------------------------------------------------------------------------
package tile_map_scheduler_pkg;

    localparam int SCR_TX  = 20;
    localparam int SCR_TY  = 15;
    localparam int TILE_PX = 8;
    localparam int MAP_TX  = 64;

    localparam int TILE_SH = $clog2(TILE_PX);
    localparam int MAP_CW  = $clog2(MAP_TX);
    localparam int COL_W   = $clog2(SCR_TX);
    localparam int ROW_W   = $clog2(SCR_TY);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_MEMWAIT = 3'd2;
    localparam logic [2:0] ST_LATCH   = 3'd3;
    localparam logic [2:0] ST_ISSUE   = 3'd4;
    localparam logic [2:0] ST_BUSY    = 3'd5;
    localparam logic [2:0] ST_NEXT    = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

endpackage

// File: rtl/tile_map_scheduler_grid_counter.sv
// ---------------------------------------------------------------------------
// tile_grid_counter
//   Column/row walker over the visible tile grid, raster order.
//
//   clock  in   system clock
//   resetn in   asynchronous active-low reset
//   clr    in   restart at row 0 / col 0
//   inc    in   advance one tile (col wraps into the next row)
//   col    out  current visible column (0..SCR_TX-1)
//   row    out  current visible row    (0..SCR_TY-1)
//   last   out  current tile is the final tile of the frame
// ---------------------------------------------------------------------------
module tile_grid_counter
    import tile_map_scheduler_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             col_end;
    logic             row_end;

    assign col_end = (col_reg == COL_W'(SCR_TX - 1));
    assign row_end = (row_reg == ROW_W'(SCR_TY - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (clr) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (inc) begin
            if (col_end) begin
                col_reg <= '0;
                // Row wraps too so an increment past the final tile is harmless.
                row_reg <= row_end ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign col  = col_reg;
    assign row  = row_reg;
    assign last = col_end && row_end;

endmodule

// File: rtl/tile_map_scheduler.sv
// ---------------------------------------------------------------------------
// tile_map_scheduler
//   Per-frame sequencer for the 8x8 tile drawer. Walks the visible grid,
//   reads each tile index from a synchronous map RAM (coarse horizontal
//   scroll applied to the column), presents origin + index to the drawer
//   with a one-cycle draw pulse and waits for drawDone before moving on.
//
//   clock       in   system clock
//   resetn      in   asynchronous active-low reset
//   frame_start in   one-cycle frame request, only honoured while idle
//   scroll_col  in   first visible map column, sampled with frame_start
//   map_addr    out  map RAM read address (1-cycle read latency)
//   map_q       in   map RAM read data
//   draw        out  one-cycle pulse to the tile drawer
//   drawDone    in   drawer idle/finished
//   tile_x      out  pixel x origin of current tile
//   tile_y      out  pixel y origin of current tile
//   tile_id     out  bitmap index of current tile
//   busy        out  frame in progress
//   frameDone   out  one-cycle pulse after the last tile
// ---------------------------------------------------------------------------
module tile_map_scheduler
    import tile_map_scheduler_pkg::*;
#(
    parameter int MAP_AW     = 10,
    parameter int ID_W       = 4,
    parameter int SKIP_EMPTY = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              frame_start,
    input  logic [MAP_CW-1:0] scroll_col,
    output logic [MAP_AW-1:0] map_addr,
    input  logic [ID_W-1:0]   map_q,
    output logic              draw,
    input  logic              drawDone,
    output logic [7:0]        tile_x,
    output logic [6:0]        tile_y,
    output logic [ID_W-1:0]   tile_id,
    output logic              busy,
    output logic              frameDone
);

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [MAP_CW-1:0] scroll_reg;
    logic [MAP_AW-1:0] map_addr_reg;
    logic [7:0]        tile_x_reg;
    logic [6:0]        tile_y_reg;
    logic [ID_W-1:0]   tile_id_reg;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              grid_last;
    logic              grid_clr;
    logic              grid_inc;

    logic [MAP_CW-1:0] map_col;
    logic [MAP_AW-1:0] fetch_addr;
    logic              tile_empty;

    assign grid_clr = (state_reg == ST_IDLE) && frame_start;
    assign grid_inc = (state_reg == ST_NEXT);

    tile_grid_counter u_grid (
        .clock  (clock),
        .resetn (resetn),
        .clr    (grid_clr),
        .inc    (grid_inc),
        .col    (col),
        .row    (row),
        .last   (grid_last)
    );

    // Column sum is held to MAP_CW bits so the scroll wraps around the map.
    // MAP_TX is a power of 2, so row*MAP_TX + column is a plain concatenation.
    assign map_col    = MAP_CW'(col) + scroll_reg;
    assign fetch_addr = MAP_AW'({row, map_col});
    assign tile_empty = (SKIP_EMPTY != 0) && (map_q == '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (frame_start) state_next = ST_FETCH;
            ST_FETCH:   state_next = ST_MEMWAIT;
            ST_MEMWAIT: state_next = ST_LATCH;
            ST_LATCH:   state_next = tile_empty ? ST_NEXT : ST_ISSUE;
            // drawDone is ignored in ISSUE: the drawer only drops it the cycle after draw.
            ST_ISSUE:   state_next = ST_BUSY;
            ST_BUSY:    if (drawDone) state_next = ST_NEXT;
            ST_NEXT:    state_next = grid_last ? ST_DONE : ST_FETCH;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            scroll_reg   <= '0;
            map_addr_reg <= '0;
            tile_x_reg   <= '0;
            tile_y_reg   <= '0;
            tile_id_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (grid_clr) begin
                scroll_reg <= scroll_col;
            end
            if (state_reg == ST_FETCH) begin
                map_addr_reg <= fetch_addr;
            end
            // Origin and index only move here, so they stay put for the whole draw.
            if (state_reg == ST_LATCH) begin
                tile_id_reg <= map_q;
                tile_x_reg  <= 8'({col, {TILE_SH{1'b0}}});
                tile_y_reg  <= 7'({row, {TILE_SH{1'b0}}});
            end
        end
    end

    // Strobes decode straight from the registered state, so they clear the
    // instant resetn falls.
    assign draw      = (state_reg == ST_ISSUE);
    assign frameDone = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign map_addr  = map_addr_reg;
    assign tile_x    = tile_x_reg;
    assign tile_y    = tile_y_reg;
    assign tile_id   = tile_id_reg;

endmodule

// File: tb/tb_tile_map_scheduler.sv
module tb_tile_map_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_start = 1'b0;
    logic [5:0] scroll_col = 6'd0;
    logic [9:0] map_addr;
    logic [3:0] map_q = 4'd0;
    logic       draw;
    logic       drawDone = 1'b1;
    logic [7:0] tile_x;
    logic [6:0] tile_y;
    logic [3:0] tile_id;
    logic       busy;
    logic       frameDone;

    tile_map_scheduler dut (
        .clock       (clock),
        .resetn      (resetn),
        .frame_start (frame_start),
        .scroll_col  (scroll_col),
        .map_addr    (map_addr),
        .map_q       (map_q),
        .draw        (draw),
        .drawDone    (drawDone),
        .tile_x      (tile_x),
        .tile_y      (tile_y),
        .tile_id     (tile_id),
        .busy        (busy),
        .frameDone   (frameDone)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [3:0] id;
    } draw_t;

    draw_t      exp_q[$];
    logic [9:0] exp_addr_q[$];

    int tests = 0;
    int fails = 0;
    int draw_cnt = 0;
    int frame_cnt = 0;
    logic [7:0] last_x = 8'd0;
    logic [6:0] last_y = 7'd0;
    logic [3:0] last_id = 4'd0;
    int drv_delay = 10;
    int dd_cnt = 0;
    logic addr_chk = 1'b0;
    logic [9:0] prev_addr = 10'd0;

    logic [3:0] mem [0:1023];

    // Synchronous map RAM, one cycle read latency.
    always @(posedge clock) map_q <= mem[map_addr];

    // Drawer model: drops drawDone the cycle after draw and holds it low drv_delay cycles.
    always @(posedge clock) begin
        if (!resetn) begin
            drawDone <= 1'b1;
            dd_cnt   <= 0;
        end else if (draw) begin
            drawDone <= (drv_delay == 0);
            dd_cnt   <= drv_delay;
        end else if (dd_cnt > 0) begin
            dd_cnt <= dd_cnt - 1;
            if (dd_cnt == 1) drawDone <= 1'b1;
        end
    end

    // Scoreboard monitor: pops the expected draw / fetch address on each DUT event.
    always @(negedge clock) begin
        draw_t e;
        logic [9:0] ea;
        if (resetn) begin
            if (draw) begin
                draw_cnt++;
                last_x  = tile_x;
                last_y  = tile_y;
                last_id = tile_id;
                $display("[TB] draw x=%0d y=%0d id=%0d", tile_x, tile_y, tile_id);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL draw_unexpected: got x=%0d y=%0d id=%0d, required no draw",
                             tile_x, tile_y, tile_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({tile_x, tile_y, tile_id} !== {e.x, e.y, e.id}) begin
                        fails++;
                        $display("FAIL draw_tile: got x=%0d y=%0d id=%0d, required x=%0d y=%0d id=%0d",
                                 tile_x, tile_y, tile_id, e.x, e.y, e.id);
                    end
                end
            end
            if (frameDone) frame_cnt++;
            if (addr_chk && (map_addr !== prev_addr) && (exp_addr_q.size() > 0)) begin
                ea = exp_addr_q.pop_front();
                $display("[TB] fetch addr=%0d", map_addr);
                tests++;
                if (map_addr !== ea) begin
                    fails++;
                    $display("FAIL map_addr_seq: got %0d, required %0d", map_addr, ea);
                end
            end
        end
        prev_addr = map_addr;
    end

    // mode 0: all 1; mode 1: map[r][c]=c+1 (4-bit); mode 2: only map[2][3]=7; mode 3: all 0
    task automatic fill_map(input int mode);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 64; c++) begin
                case (mode)
                    0:       mem[r*64+c] = 4'd1;
                    1:       mem[r*64+c] = 4'((c + 1) % 16);
                    2:       mem[r*64+c] = (r == 2 && c == 3) ? 4'd7 : 4'd0;
                    default: mem[r*64+c] = 4'd0;
                endcase
            end
        end
    endtask

    task automatic push_frame(input int scroll);
        draw_t e;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                e.id = mem[r*64 + ((c + scroll) % 64)];
                e.x  = 8'(c * 8);
                e.y  = 7'(r * 8);
                if (e.id != 4'd0) exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input logic [5:0] s);
        @(negedge clock);
        scroll_col  = s;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until frameDone is seen (bounded).
    task automatic wait_frame(input int budget, output int cyc);
        cyc = 0;
        while (frameDone !== 1'b1 && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        tests++;
        if ({draw, busy, frameDone, map_addr, tile_x, tile_y, tile_id} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got draw=%b busy=%b fd=%b addr=%0d x=%0d y=%0d id=%0d, required all 0",
                     draw, busy, frameDone, map_addr, tile_x, tile_y, tile_id);
        end
        resetn = 1'b1;
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_full_frame;
        int cyc, d0, f0;
        fill_map(0);
        drv_delay = 10;
        push_frame(0);
        d0 = draw_cnt;
        f0 = frame_cnt;
        start_frame(6'd0);
        wait_frame(20000, cyc);
        tests++;
        if (cyc != 300 * 16) begin
            fails++;
            $display("FAIL full_frame_cycles: got %0d, required %0d", cyc, 300 * 16);
        end
        @(negedge clock);
        tests++;
        if (draw_cnt - d0 != 300) begin
            fails++;
            $display("FAIL full_frame_draws: got %0d, required 300", draw_cnt - d0);
        end
        tests++;
        if (last_x !== 8'd152 || last_y !== 7'd112) begin
            fails++;
            $display("FAIL full_frame_last_tile: got x=%0d y=%0d, required x=152 y=112", last_x, last_y);
        end
        tests++;
        if (frame_cnt - f0 != 1) begin
            fails++;
            $display("FAIL full_frame_done_count: got %0d, required 1", frame_cnt - f0);
        end
        tests++;
        if (busy !== 1'b0 || frameDone !== 1'b0) begin
            fails++;
            $display("FAIL full_frame_end: got busy=%b frameDone=%b, required 0 0", busy, frameDone);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL full_frame_missing: got %0d undrawn, required 0", exp_q.size());
        end
    endtask

    task automatic test_scroll_wrap;
        int cyc, f0;
        fill_map(1);
        drv_delay = 1;
        for (int c = 0; c < 20; c++) exp_addr_q.push_back(10'((60 + c) % 64));
        push_frame(60);
        f0 = frame_cnt;
        addr_chk = 1'b1;
        start_frame(6'd60);
        scroll_col = 6'd33;   // must not affect the frame in flight
        wait_frame(20000, cyc);
        @(negedge clock);
        addr_chk = 1'b0;
        tests++;
        if (exp_addr_q.size() != 0) begin
            fails++;
            $display("FAIL scroll_addr_count: got %0d addresses unseen, required 0", exp_addr_q.size());
        end
        tests++;
        if (exp_q.size() != 0 || frame_cnt - f0 != 1) begin
            fails++;
            $display("FAIL scroll_frame: got %0d undrawn and %0d frames, required 0 and 1",
                     exp_q.size(), frame_cnt - f0);
        end
        exp_addr_q.delete();
    endtask

    task automatic test_skip_empty;
        int cyc, d0;
        fill_map(2);
        drv_delay = 10;
        push_frame(0);
        d0 = draw_cnt;
        start_frame(6'd0);
        wait_frame(20000, cyc);
        tests++;
        if (cyc != 300 * 4 + 1 + 10 + 1) begin
            fails++;
            $display("FAIL skip_cycles: got %0d, required %0d", cyc, 300 * 4 + 12);
        end
        @(negedge clock);
        tests++;
        if (draw_cnt - d0 != 1) begin
            fails++;
            $display("FAIL skip_draws: got %0d, required 1", draw_cnt - d0);
        end
        tests++;
        if (last_x !== 8'd24 || last_y !== 7'd16 || last_id !== 4'd7) begin
            fails++;
            $display("FAIL skip_tile: got x=%0d y=%0d id=%0d, required 24 16 7", last_x, last_y, last_id);
        end
    endtask

    task automatic test_frame_start_ignored;
        int cyc, f0, d0;
        logic stray;
        fill_map(3);
        f0 = frame_cnt;
        d0 = draw_cnt;
        start_frame(6'd0);
        repeat (100) @(negedge clock);
        scroll_col  = 6'd7;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        wait_frame(20000, cyc);
        tests++;
        if (cyc + 101 != 1200) begin
            fails++;
            $display("FAIL ignore_cycles: got %0d, required 1200", cyc + 101);
        end
        stray = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (busy !== 1'b0) stray = 1'b1;
        end
        tests++;
        if (stray !== 1'b0 || frame_cnt - f0 != 1 || draw_cnt != d0) begin
            fails++;
            $display("FAIL ignore_second_frame: got busy_after=%b frames=%0d draws=%0d, required 0 1 0",
                     stray, frame_cnt - f0, draw_cnt - d0);
        end
    endtask

    task automatic test_handshake;
        int n;
        logic [9:0] a0;
        logic [7:0] x0;
        logic [6:0] y0;
        logic [3:0] i0;
        logic held;
        fill_map(0);
        drv_delay = 50;
        push_frame(0);
        start_frame(6'd0);
        n = 0;
        while (draw !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        a0 = map_addr; x0 = tile_x; y0 = tile_y; i0 = tile_id;
        tests++;
        if (draw !== 1'b1 || a0 !== 10'd0 || i0 !== 4'd1) begin
            fails++;
            $display("FAIL hs_first_draw: got draw=%b addr=%0d id=%0d, required 1 0 1", draw, a0, i0);
        end
        held = 1'b1;
        repeat (51) begin
            @(negedge clock);
            if (draw !== 1'b0 || map_addr !== a0 || tile_x !== x0 || tile_y !== y0 || tile_id !== i0)
                held = 1'b0;
        end
        tests++;
        if (held !== 1'b1) begin
            fails++;
            $display("FAIL hs_hold: got held=%b, required 1", held);
        end
        n = 0;
        while (map_addr !== 10'd1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (map_addr !== 10'd1) begin
            fails++;
            $display("FAIL hs_resume: got addr=%0d, required 1", map_addr);
        end
    endtask

    task automatic test_reset_mid_busy;
        int n, cyc, d0, f0;
        n = 0;
        while (draw !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        tests++;
        if ({draw, busy, frameDone, map_addr, tile_x, tile_y, tile_id} !== '0) begin
            fails++;
            $display("FAIL async_reset: got draw=%b busy=%b fd=%b addr=%0d x=%0d y=%0d id=%0d, required all 0",
                     draw, busy, frameDone, map_addr, tile_x, tile_y, tile_id);
        end
        exp_q.delete();
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        drv_delay = 1;
        push_frame(0);
        d0 = draw_cnt;
        f0 = frame_cnt;
        start_frame(6'd0);
        wait_frame(20000, cyc);
        @(negedge clock);
        tests++;
        if (draw_cnt - d0 != 300 || frame_cnt - f0 != 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL post_reset_frame: got draws=%0d frames=%0d undrawn=%0d, required 300 1 0",
                     draw_cnt - d0, frame_cnt - f0, exp_q.size());
        end
    endtask

    initial begin
        fill_map(3);
        test_reset;
        test_full_frame;
        test_scroll_wrap;
        test_skip_empty;
        test_frame_start_ignored;
        test_handshake;
        test_reset_mid_busy;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
